// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: issues single-outstanding word reads to instruction memory,
// buffers results in a small prefetch FIFO and presents them to the control unit.
module instruction_fetch_unit #(
  parameter int                ADDR_W   = 16,
  parameter int                DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
  input  logic              CLOCK,
  input  logic              RESET,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [15:0]       imem_rdata,
  output logic [15:0]       COMMAND,
  output logic [ADDR_W-1:0] cmd_pc,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  input  logic              PC_load,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              halt,
  output logic [ADDR_W-1:0] fetch_pc
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {IDLE, FETCH, FLUSH, HALTED} state_t;
  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [15:0]       insn;
  } entry_t;

  state_t            state, state_n;
  entry_t [DEPTH-1:0] mem;
  entry_t            head_n;
  logic [PW-1:0]     rd_ptr, wr_ptr, rd_ptr_n;
  logic [CW-1:0]     count, count_left, count_n;
  logic              push, pop, issue, launch, req_n;
  logic [ADDR_W-1:0] fpc_n, launch_addr, addr_n;

  // A redirect discards both the same-cycle pop and push.
  assign pop        = cmd_valid & cmd_ready & ~PC_load;
  assign push       = (state == FETCH) & imem_ack & ~PC_load;
  assign count_left = count - CW'(pop);
  assign count_n    = PC_load ? '0 : count_left + CW'(push);
  assign rd_ptr_n   = rd_ptr + PW'(pop);
  assign issue      = (count_n < CW'(DEPTH)) & ~halt;

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n     = state;
    fpc_n       = fetch_pc;
    launch      = 1'b0;
    launch_addr = fetch_pc;
    if (PC_load) begin
      fpc_n = branch_target;
      // A pending stale request must finish before the target may be requested.
      if ((state == FETCH || state == FLUSH) && !imem_ack) state_n = FLUSH;
      else if (issue) begin
        state_n     = FETCH;
        launch      = 1'b1;
        launch_addr = branch_target;
      end else state_n = halt ? HALTED : IDLE;
    end else begin
      case (state)
        IDLE:
          if (issue) begin
            state_n = FETCH;
            launch  = 1'b1;
          end else if (halt) state_n = HALTED;
        FETCH:
          if (imem_ack) begin
            fpc_n = fetch_pc + ADDR_W'(1);
            if (issue) begin
              launch      = 1'b1;
              launch_addr = fetch_pc + ADDR_W'(1);
            end else state_n = halt ? HALTED : IDLE;
          end
        FLUSH:
          if (imem_ack) begin
            if (issue) begin
              state_n = FETCH;
              launch  = 1'b1;
            end else state_n = halt ? HALTED : IDLE;
          end
        HALTED:
          if (!halt) state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_comb begin
    req_n  = (state_n == FETCH) || (state_n == FLUSH);
    addr_n = launch ? launch_addr : imem_addr;
  end

  // Next head: freshly acked word when the FIFO would otherwise be empty.
  always_comb begin
    head_n = mem[rd_ptr_n];
    if (count_left == '0) head_n = '{pc: fetch_pc, insn: imem_rdata};
    if (count_n == '0)    head_n = '0;
  end

  always_ff @(posedge CLOCK) begin
    if (push) mem[wr_ptr] <= '{pc: fetch_pc, insn: imem_rdata};
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
      fetch_pc  <= RESET_PC;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      cmd_valid <= 1'b0;
      COMMAND   <= '0;
      cmd_pc    <= '0;
    end else begin
      imem_req  <= req_n;
      imem_addr <= addr_n;
      fetch_pc  <= fpc_n;
      rd_ptr    <= PC_load ? '0 : rd_ptr_n;
      wr_ptr    <= PC_load ? '0 : wr_ptr + PW'(push);
      count     <= count_n;
      cmd_valid <= (count_n != '0);
      COMMAND   <= head_n.insn;
      cmd_pc    <= head_n.pc;
    end
  end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench: expected cmd_pc order is queued by each scenario and checked as
// the control-unit side consumes words; memory answers with a configurable latency.
module tb_instruction_fetch_unit;
  logic        CLOCK = 1'b0;
  logic        RESET = 1'b1;
  logic        imem_req, imem_ack, cmd_valid, cmd_ready, PC_load, halt;
  logic [15:0] imem_addr, imem_rdata, COMMAND, cmd_pc, branch_target, fetch_pc;
  logic        a_req, a_valid;
  logic [15:0] a_addr, a_cmd, a_pc, a_fpc;

  always #5 CLOCK = ~CLOCK;

  instruction_fetch_unit #(.ADDR_W(16), .DEPTH(2), .RESET_PC(16'h0000)) u_dut (
    .CLOCK(CLOCK), .RESET(RESET), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .COMMAND(COMMAND), .cmd_pc(cmd_pc),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .PC_load(PC_load),
    .branch_target(branch_target), .halt(halt), .fetch_pc(fetch_pc));

  // Second instance only checks a non-zero reset PC; it is held halted.
  instruction_fetch_unit #(.ADDR_W(16), .DEPTH(2), .RESET_PC(16'hFFFE)) u_alt (
    .CLOCK(CLOCK), .RESET(RESET), .imem_req(a_req), .imem_addr(a_addr),
    .imem_ack(1'b0), .imem_rdata(16'h0000), .COMMAND(a_cmd), .cmd_pc(a_pc),
    .cmd_valid(a_valid), .cmd_ready(1'b0), .PC_load(1'b0),
    .branch_target(16'h0000), .halt(1'b1), .fetch_pc(a_fpc));

  int total = 0, bad = 0, npop = 0, lat = 0, cnt = 0;
  logic [15:0] q[$];
  logic        auto_ack = 1'b1, r_ack = 1'b0, m_ack = 1'b0;
  logic [15:0] r_data = '0, m_data = '0;

  assign imem_ack   = auto_ack ? r_ack : m_ack;
  assign imem_rdata = auto_ack ? r_data : m_data;

  function automatic logic [15:0] word_of(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h1234;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLOCK);
    #1;
  endtask

  task automatic do_reset;
    RESET = 1'b1; PC_load = 1'b0; halt = 1'b0; cmd_ready = 1'b0;
    branch_target = '0; auto_ack = 1'b1; m_ack = 1'b0;
    tick; tick;
    q.delete(); npop = 0;
    RESET = 1'b0;
  endtask

  task automatic wait_addr(input logic [15:0] a, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (imem_req && imem_addr == a) begin
        ok = 1'b1;
        break;
      end
      tick;
    end
  endtask

  // Memory model: acks the outstanding request after 'lat' idle cycles.
  always @(negedge CLOCK) begin
    if (RESET || !imem_req) begin
      cnt = 0; r_ack = 1'b0;
    end else if (cnt >= lat) begin
      r_ack = 1'b1; r_data = word_of(imem_addr); cnt = 0;
    end else begin
      r_ack = 1'b0; cnt++;
    end
  end

  // Consumer-side scoreboard.
  always @(negedge CLOCK) begin
    if (!RESET) begin
      if (!cmd_valid) chk("idle_zero", {COMMAND, cmd_pc}, 32'h0);
      else if (cmd_ready && !PC_load) begin
        if (q.size() == 0) chk("sb_extra", {16'h0, cmd_pc}, 32'hFFFF_FFFF);
        else begin
          logic [15:0] e;
          e = q.pop_front();
          chk("cmd_pc", 32'(cmd_pc), 32'(e));
          chk("command", 32'(COMMAND), 32'(word_of(e)));
          npop++;
        end
      end
    end
  end

  initial begin
    bit ok, seen;
    int n0;
    cmd_ready = 0; PC_load = 0; halt = 0; branch_target = '0;

    // Reset values and back-to-back single-cycle acks
    lat = 0;
    do_reset;
    RESET = 1'b1; tick;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'h0);
    chk("rst_fpc", 32'(fetch_pc), 32'h0);
    chk("rst_valid", 32'(cmd_valid), 32'd0);
    chk("rst_cmd", {COMMAND, cmd_pc}, 32'h0);
    chk("alt_rst_pc", {a_fpc, a_addr}, 32'hFFFE_FFFE);
    for (int i = 0; i < 16; i++) q.push_back(16'(i));
    cmd_ready = 1'b1; RESET = 1'b0;
    tick;
    chk("b2b_addr0", {15'h0, imem_req, imem_addr}, {15'h0, 1'b1, 16'h0000});
    chk("b2b_v0", 32'(cmd_valid), 32'd0);
    tick;
    chk("b2b_addr1", 32'(imem_addr), 32'h0001);
    chk("b2b_pc0", {15'h0, cmd_valid, cmd_pc}, {15'h0, 1'b1, 16'h0000});
    tick;
    chk("b2b_addr2", 32'(imem_addr), 32'h0002);
    chk("b2b_pc1", 32'(cmd_pc), 32'h0001);
    repeat (5) tick;
    chk("b2b_rate", 32'(npop), 32'd6);

    // Backpressure fills the FIFO to exactly DEPTH words
    lat = 2;
    do_reset;
    for (int i = 0; i < 16; i++) q.push_back(16'(i));
    repeat (20) tick;
    chk("full_req", 32'(imem_req), 32'd0);
    chk("full_fpc", 32'(fetch_pc), 32'h0002);
    chk("full_head", {15'h0, cmd_valid, cmd_pc}, {15'h0, 1'b1, 16'h0000});
    cmd_ready = 1'b1;
    tick;
    chk("resume", {15'h0, imem_req, imem_addr}, {15'h0, 1'b1, 16'h0002});
    repeat (15) tick;
    chk("resume_out", 32'(npop >= 4), 32'd1);

    // Redirect while a request is outstanding
    lat = 3;
    do_reset;
    for (int i = 0; i < 6; i++) q.push_back(16'(i));
    cmd_ready = 1'b1;
    wait_addr(16'h0005, 60, ok);
    chk("br_reach5", 32'(ok), 32'd1);
    PC_load = 1'b1; branch_target = 16'h0040;
    q.delete();
    for (int i = 0; i < 16; i++) q.push_back(16'h0040 + 16'(i));
    n0 = npop;
    tick;
    PC_load = 1'b0;
    chk("br_hold", {15'h0, imem_req, imem_addr}, {15'h0, 1'b1, 16'h0005});
    chk("br_fpc", 32'(fetch_pc), 32'h0040);
    chk("br_clear", 32'(cmd_valid), 32'd0);
    wait_addr(16'h0040, 20, ok);
    chk("br_target", 32'(ok), 32'd1);
    repeat (20) tick;
    chk("br_out", 32'(npop > n0), 32'd1);

    // Address wrap at 0xFFFF
    lat = 0;
    do_reset;
    PC_load = 1'b1; branch_target = 16'hFFFE; cmd_ready = 1'b1;
    for (int i = 0; i < 16; i++) q.push_back(16'hFFFE + 16'(i));
    tick;
    PC_load = 1'b0;
    chk("wrap_addr", {imem_addr, fetch_pc}, 32'hFFFE_FFFE);
    repeat (8) tick;
    chk("wrap_out", 32'(npop >= 3), 32'd1);

    // Halt during an outstanding request
    lat = 2;
    do_reset;
    for (int i = 0; i < 16; i++) q.push_back(16'(i));
    cmd_ready = 1'b1;
    wait_addr(16'h0003, 60, ok);
    chk("halt_reach3", 32'(ok), 32'd1);
    halt = 1'b1;
    repeat (4) tick;
    seen = 1'b0;
    repeat (6) begin tick; seen |= imem_req; end
    chk("halt_noreq", 32'(seen), 32'd0);
    chk("halt_fpc", 32'(fetch_pc), 32'h0004);
    chk("halt_state", 32'(u_dut.state), 32'd3);
    chk("halt_deliv", 32'(npop), 32'd4);
    halt = 1'b0;
    tick;
    wait_addr(16'h0004, 5, ok);
    chk("unhalt", 32'(ok), 32'd1);
    repeat (12) tick;
    chk("unhalt_out", 32'(npop >= 5), 32'd1);

    // Async reset mid-request, then a stray ack
    lat = 5;
    do_reset;
    tick; tick;
    chk("mid_pre", 32'(imem_req), 32'd1);
    #2 RESET = 1'b1;
    #1;
    chk("mid_req", 32'(imem_req), 32'd0);
    chk("mid_addr", {imem_addr, fetch_pc}, 32'h0);
    auto_ack = 1'b0; m_ack = 1'b1; m_data = 16'hDEAD;
    tick; tick;
    RESET = 1'b0;
    tick;
    m_ack = 1'b0;
    chk("stray_v", 32'(cmd_valid), 32'd0);
    chk("stray_req", {15'h0, imem_req, imem_addr}, {15'h0, 1'b1, 16'h0000});
    tick;
    chk("stray_v2", 32'(cmd_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
